// File: rtl/ifetch_aligner.sv
// ============================================================================
// Module   : ifetch_aligner
// Brief    : Fetch responder returning the 16/32-bit instruction at pc_in from
//            a two-word buffer over a word-addressed instruction memory.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ifetch_aligner #(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [XLEN-1:0] pc_in,
    output logic            mem_req_valid,
    output logic [XLEN-1:0] mem_req_addr,
    input  logic            mem_req_ready,
    input  logic            mem_rsp_valid,
    input  logic [31:0]     mem_rsp_data,
    output logic            instr_valid,
    output logic [31:0]     instr,
    output logic            instr_rvc,
    output logic            stall
);

    localparam int c_TAG_W = XLEN - 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t             r_state;
    logic [c_TAG_W-1:0] r_cur_tag;
    logic               r_cur_v;
    logic [31:0]        r_cur_w;
    logic               r_nxt_v;
    logic [31:0]        r_nxt_w;
    logic [c_TAG_W-1:0] r_req_tag;
    logic               r_req_valid;

    logic [c_TAG_W-1:0] w_ptag;
    logic [c_TAG_W-1:0] w_cur_tag_inc;
    logic               w_hc;
    logic               w_hn;
    logic               w_miss;
    logic               w_shift;
    logic [31:0]        w_base;
    logic               w_ext_v;
    logic [15:0]        w_half;
    logic               w_rvc;
    logic               w_valid;
    logic [31:0]        w_instr_raw;
    logic [c_TAG_W-1:0] w_ps_cur_tag;
    logic [c_TAG_W-1:0] w_ps_cur_tag_inc;
    logic               w_ps_cur_v;
    logic               w_ps_nxt_v;
    logic               w_unused_pc0;

    assign w_unused_pc0  = pc_in[0];

    // Hit detection against the buffered pair (cur, cur+1)
    assign w_ptag        = pc_in[XLEN-1:2];
    assign w_cur_tag_inc = r_cur_tag + c_TAG_W'(1);
    assign w_hc          = r_cur_v && (w_ptag == r_cur_tag);
    assign w_hn          = r_nxt_v && (w_ptag == w_cur_tag_inc);
    assign w_miss        = !w_hc && !w_hn;
    assign w_shift       = w_hn && !w_hc;

    // When the pc sits in nxt there is no word after it yet, so a straddling
    // instruction there must wait for the shift and the following refill.
    assign w_base  = w_hc ? r_cur_w : r_nxt_w;
    assign w_ext_v = w_hc && r_nxt_v;
    assign w_half  = pc_in[1] ? w_base[31:16] : w_base[15:0];
    assign w_rvc   = (w_half[1:0] != 2'b11);

    always_comb begin
        w_valid     = 1'b0;
        w_instr_raw = w_base;
        if (w_rvc) begin
            w_valid     = w_hc || w_hn;
            w_instr_raw = {16'b0, w_half};
        end else if (pc_in[1]) begin
            w_valid     = w_ext_v;
            w_instr_raw = {r_nxt_w[15:0], w_half};
        end else begin
            w_valid     = w_hc || w_hn;
            w_instr_raw = w_base;
        end
    end

    assign instr_valid   = w_valid;
    assign instr         = w_valid ? w_instr_raw : 32'b0;
    assign instr_rvc     = w_valid && w_rvc;
    assign stall         = !w_valid;
    assign mem_req_valid = r_req_valid;
    assign mem_req_addr  = {r_req_tag, 2'b00};

    // Buffer view after this edge's shift; response placement uses it
    assign w_ps_cur_tag     = w_shift ? w_cur_tag_inc : r_cur_tag;
    assign w_ps_cur_tag_inc = w_ps_cur_tag + c_TAG_W'(1);
    assign w_ps_cur_v       = w_shift ? 1'b1 : r_cur_v;
    assign w_ps_nxt_v       = w_shift ? 1'b0 : r_nxt_v;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_cur_tag   <= '0;
            r_cur_v     <= 1'b0;
            r_cur_w     <= '0;
            r_nxt_v     <= 1'b0;
            r_nxt_w     <= '0;
            r_req_tag   <= '0;
            r_req_valid <= 1'b0;
        end else begin
            if (w_shift) begin
                r_cur_w   <= r_nxt_w;
                r_cur_tag <= w_cur_tag_inc;
                r_cur_v   <= 1'b1;
                r_nxt_v   <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_miss) begin
                        r_cur_tag   <= w_ptag;
                        r_cur_v     <= 1'b0;
                        r_nxt_v     <= 1'b0;
                        r_req_tag   <= w_ptag;
                        r_req_valid <= 1'b1;
                        r_state     <= S_REQ;
                    end else if (r_cur_v && !r_nxt_v && !w_shift) begin
                        r_req_tag   <= w_cur_tag_inc;
                        r_req_valid <= 1'b1;
                        r_state     <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (mem_req_ready) begin
                        r_req_valid <= 1'b0;
                        r_state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem_rsp_valid) begin
                        r_state <= S_IDLE;
                        // Anything not matching the buffer is simply dropped;
                        // a word address always returns the same data.
                        if (!w_ps_cur_v && (r_req_tag == w_ps_cur_tag)) begin
                            r_cur_w <= mem_rsp_data;
                            r_cur_v <= 1'b1;
                        end else if (!w_ps_nxt_v && (r_req_tag == w_ps_cur_tag_inc)) begin
                            r_nxt_w <= mem_rsp_data;
                            r_nxt_v <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_req_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/ifetch_aligner.md
Name: ifetch_aligner

Overview:
- Instruction-fetch responder between the PC register / next-address logic and a 32-bit word-addressed instruction memory.
- Takes the current pc and returns the instruction at that pc, handling 16-bit compressed (RVC) instructions and 32-bit instructions that straddle a word boundary.
- Keeps a two-word buffer (cur, nxt), prefetches sequentially, and refills on any non-sequential pc.
- Drives the pc stall and the rvc size flag back to the address generator.

Parameters:
XLEN, 32, address/pc width; instruction data width is fixed at 32.

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low
pc_in  input  XLEN  current pc from the PC register; bit 0 ignored
mem_req_valid  output  1  fetch request valid
mem_req_addr  output  XLEN  word-aligned fetch address, {req_tag, 2'b00}
mem_req_ready  input  1  memory accepts request when high with mem_req_valid
mem_rsp_valid  input  1  read data valid, exactly one per accepted request, in order, at least 1 cycle after acceptance
mem_rsp_data  input  32  read data
instr_valid  output  1  instr/instr_rvc valid for pc_in this cycle
instr  output  32  instruction; RVC zero-extended in [15:0]
instr_rvc  output  1  instruction is 16-bit (feeds s_rvc)
stall  output  1  ~instr_valid; drives pc pause

Behaviour:
- State: cur_tag[XLEN-3:0], cur_v, cur_w[31:0], nxt_v, nxt_w[31:0]. nxt always holds word cur_tag+1 (mod 2^(XLEN-2), wraps).
- FSM: IDLE, REQ (mem_req_valid=1, addr held stable until ready), WAIT (awaiting mem_rsp_valid). At most one outstanding request.
- Reset (async): IDLE, cur_v=nxt_v=0, cur_tag=0, mem_req_valid=0. Hence instr_valid=0, stall=1, instr=0, instr_rvc=0.
- Hit logic (combinational):
  - ptag=pc_in[XLEN-1:2]; hc = cur_v && ptag==cur_tag; hn = nxt_v && ptag==cur_tag+1.
  - base = hc ? cur_w : nxt_w. ext = hc ? nxt_w, with ext_v = nxt_v; when hn, ext_v = 0.
  - half = pc_in[1] ? base[31:16] : base[15:0]; instr_rvc = (half[1:0] != 2'b11).
  - pc_in[1]=0: instr = rvc ? {16'b0,half} : base; valid = hc||hn.
  - pc_in[1]=1: rvc gives {16'b0,half}, valid = hc||hn. Non-rvc gives {ext[15:0],half}, valid = hc && ext_v.
  - Outputs are 0 when not valid.
- Shift: at an edge with hn && !hc, cur_w<=nxt_w, cur_tag<=cur_tag+1, nxt_v<=0.
- Request issue, only from IDLE, first match wins:
  1. Miss (!hc && !hn): cur_tag<=ptag, cur_v<=0, nxt_v<=0, req_tag=ptag.
  2. cur valid, nxt invalid, no shift this edge: req_tag=cur_tag+1 (prefetch or straddle fill).
  3. Otherwise stay IDLE.
- Issue enters REQ at the edge, so mem_req_valid is registered.
- REQ goes to WAIT at an edge with mem_req_ready.
- WAIT goes to IDLE at an edge with mem_rsp_valid.
- Response placement, in the same edge, using post-shift state:
  - If !cur_v && req_tag==cur_tag: fill cur.
  - Else if !nxt_v && req_tag==cur_tag+1: fill nxt.
  - Otherwise discard. Stale data from a word address is identical, so no drop flag is needed.
- A miss detected in REQ/WAIT takes effect only when IDLE is re-entered: the pending request completes first.
- mem_rsp_valid outside WAIT is ignored. This covers reset mid-transaction.
- pc_in may change while stalled. Outputs always track the current pc_in.
- Minimum miss latency with ready=1 and 1-cycle response: instr_valid 3 edges after the miss is presented (issue, accept, fill).

Test Plan:
- Reset low mid-WAIT with rsp arriving after release -> outputs 0/stall=1 during reset; stray rsp ignored; first fill only from new request at pc_in.
- pc=0x0, mem[0]=0x00000013 (32-bit), ready=1, 1-cycle rsp -> mem_req_addr=0x0; instr_valid after 3 edges; instr=0x00000013, rvc=0; prefetch addr 0x4 follows.
- pc=0x2, mem[0]=0x0513_4501, mem[4]=0x0000_0001 -> half 0x0513 non-rvc, stall until nxt filled; instr=0x00010513, rvc=0.
- pc=0x2 with mem[0][31:16]=0x4505 -> rvc=1, instr=0x00004505, valid from cur only, no wait for nxt.
- Redirect during WAIT (pc 0x4 -> 0x100) -> pending rsp discarded; next request 0x100; stall held until filled.
- Sequential pc 0x0,0x4,0x8 with ready=1 -> shift on reaching nxt; no stall at 0x4; pc=0xFFFFFFFC prefetches 0x00000000 (wrap).
